// File: rtl/adder_slice_seq.sv
// rtl/adder_slice_seq.sv - multi-cycle WIDTH-bit adder sequenced through an external ripple slice
//
// Feeds one SLICE_W-bit operand slice per cycle to an external adder slice. It captures each
// slice sum verbatim and chains the slice carry into the next slice. Operands are zero-padded
// to NSLICE*SLICE_W bits.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   in_valid/in_ready              operand request handshake
//   in_a, in_b, in_cin             operands and carry-in, sampled only on acceptance
//   sl_a, sl_b, sl_cin             operand slice and carry driven to the external slice
//   sl_sum, sl_cout                combinational result returned by the external slice
//   out_valid/out_ready            result handshake
//   out_sum, out_cout              result (mod 2^WIDTH) and carry out of bit WIDTH-1
module adder_slice_seq #(
   parameter int WIDTH   = 12,
   parameter int SLICE_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_cin,
   output logic [SLICE_W-1:0] sl_a,
   output logic [SLICE_W-1:0] sl_b,
   output logic               sl_cin,
   input  logic [SLICE_W-1:0] sl_sum,
   input  logic               sl_cout,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_sum,
   output logic               out_cout
);

   localparam int NSLICE = (WIDTH + SLICE_W - 1) / SLICE_W;
   localparam int PW     = NSLICE * SLICE_W;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   a_r;
   logic [PW-1:0]   b_r;
   logic [PW-1:0]   sum_r;
   logic            carry_r;
   logic [IW-1:0]   idx;
   logic            last_slice;
   logic            pad_cout;

   assign last_slice = (idx == LAST_IDX);

   // Bit WIDTH of the padded sum. With padding, the top slice already produced it as a sum bit;
   // without padding it is the final slice carry.
   generate
      if (PW > WIDTH) begin : g_pad
         assign pad_cout = sum_r[WIDTH];
      end else begin : g_nopad
         assign pad_cout = carry_r;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         idx     <= '0;
      end else begin
         case (state)
            IDLE: begin
               // in_ready is 1 throughout IDLE, so in_valid alone marks acceptance.
               if (in_valid) begin
                  a_r     <= PW'(in_a);
                  b_r     <= PW'(in_b);
                  carry_r <= in_cin;
                  sum_r   <= '0;
                  idx     <= '0;
               end
            end
            RUN: begin
               sum_r[idx*SLICE_W +: SLICE_W] <= sl_sum;
               carry_r                       <= sl_cout;
               idx                           <= last_slice ? '0 : idx + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_sum   = '0;
      out_cout  = 1'b0;
      sl_a      = '0;
      sl_b      = '0;
      sl_cin    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            sl_a   = a_r[idx*SLICE_W +: SLICE_W];
            sl_b   = b_r[idx*SLICE_W +: SLICE_W];
            sl_cin = carry_r;
            if (last_slice) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            out_sum   = sum_r[WIDTH-1:0];
            out_cout  = pad_cout;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_adder_slice_seq.sv
// tb/tb_adder_slice_seq.sv - self-checking bench for adder_slice_seq (WIDTH=12 and padded WIDTH=10)
module tb_adder_slice_seq;

   int tests_run    = 0;
   int tests_failed = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic        in_cin;
   logic        out_ready;
   logic        stub;
   logic        sel10;
   logic [11:0] in_a;
   logic [11:0] in_b;

   // WIDTH=12 instance
   logic        in_valid12, in_ready12, out_ready12, out_valid12, out_cout12;
   logic        sl_cin12, sl_cout12;
   logic [2:0]  sl_a12, sl_b12, sl_sum12;
   logic [11:0] out_sum12;
   logic [3:0]  s12;

   // WIDTH=10 instance
   logic        in_valid10, in_ready10, out_ready10, out_valid10, out_cout10;
   logic        sl_cin10, sl_cout10;
   logic [2:0]  sl_a10, sl_b10, sl_sum10;
   logic [9:0]  out_sum10;
   logic [3:0]  s10;

   assign in_valid12  = in_valid & ~sel10;
   assign out_ready12 = out_ready & ~sel10;
   assign in_valid10  = in_valid & sel10;
   assign out_ready10 = out_ready & sel10;

   // External slice models: exact 3-bit ripple adder, or a stub forcing sum=0/cout=1.
   assign s12       = {1'b0, sl_a12} + {1'b0, sl_b12} + {3'b000, sl_cin12};
   assign sl_sum12  = stub ? 3'b000 : s12[2:0];
   assign sl_cout12 = stub ? 1'b1 : s12[3];
   assign s10       = {1'b0, sl_a10} + {1'b0, sl_b10} + {3'b000, sl_cin10};
   assign sl_sum10  = s10[2:0];
   assign sl_cout10 = s10[3];

   logic        in_ready_m, out_valid_m, out_cout_m, sl_cin_m;
   logic [11:0] out_sum_m;
   assign in_ready_m  = sel10 ? in_ready10  : in_ready12;
   assign out_valid_m = sel10 ? out_valid10 : out_valid12;
   assign out_cout_m  = sel10 ? out_cout10  : out_cout12;
   assign sl_cin_m    = sel10 ? sl_cin10    : sl_cin12;
   assign out_sum_m   = sel10 ? {2'b00, out_sum10} : out_sum12;

   adder_slice_seq #(.WIDTH(12), .SLICE_W(3)) dut12 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid12), .in_ready(in_ready12),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .sl_a(sl_a12), .sl_b(sl_b12), .sl_cin(sl_cin12),
      .sl_sum(sl_sum12), .sl_cout(sl_cout12),
      .out_valid(out_valid12), .out_ready(out_ready12),
      .out_sum(out_sum12), .out_cout(out_cout12)
   );

   adder_slice_seq #(.WIDTH(10), .SLICE_W(3)) dut10 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid10), .in_ready(in_ready10),
      .in_a(in_a[9:0]), .in_b(in_b[9:0]), .in_cin(in_cin),
      .sl_a(sl_a10), .sl_b(sl_b10), .sl_cin(sl_cin10),
      .sl_sum(sl_sum10), .sl_cout(sl_cout10),
      .out_valid(out_valid10), .out_ready(out_ready10),
      .out_sum(out_sum10), .out_cout(out_cout10)
   );

   // Reference: {cout, sum} of a w-bit add with carry-in.
   function automatic logic [12:0] ref_add(input int w, input logic [11:0] a, input logic [11:0] b,
                                           input logic c);
      int mask;
      int full;
      logic [12:0] r;
      mask  = (1 << w) - 1;
      full  = (int'(a) & mask) + (int'(b) & mask) + int'(c);
      r[11:0] = 12'(full & mask);
      r[12]   = 1'((full >> w) & 1);
      return r;
   endfunction

   // Reference: carry into 3-bit slice k, i.e. the carry out of the low 3k bits.
   function automatic logic ref_cin(input int w, input logic [11:0] a, input logic [11:0] b,
                                    input logic c, input int k);
      int mask;
      int m;
      int part;
      mask = (1 << w) - 1;
      m    = (1 << (3 * k)) - 1;
      part = (int'(a) & mask & m) + (int'(b) & mask & m) + int'(c);
      return 1'((part >> (3 * k)) & 1);
   endfunction

   // Starts at a negedge with the selected DUT idle; returns at the negedge where out_valid is
   // seen (or a cycle budget expires), leaving the result pending.
   task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic c,
                         output logic [11:0] s, output logic co, output int lat,
                         output logic [3:0] cins, output logic ok);
      int guard;
      cins     = '0;
      in_a     = a;
      in_b     = b;
      in_cin   = c;
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready_m && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid_m && lat < 16) begin
         if (lat < 4) cins[lat] = sl_cin_m;
         @(negedge clk);
         lat++;
      end
      ok = out_valid_m;
      s  = out_sum_m;
      co = out_cout_m;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stub = 1'b0; sel10 = 1'b0;
      in_a = '0; in_b = '0; in_cin = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tests_run++; if (in_ready12 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", in_ready12); end
      tests_run++; if (out_valid12 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid12); end
      tests_run++; if (out_sum12 !== 12'h000) begin tests_failed++; $display("FAIL reset_out_sum got %h exp 000", out_sum12); end
      tests_run++; if (out_cout12 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_cout got %b exp 0", out_cout12); end
      tests_run++; if ({sl_a12, sl_b12, sl_cin12} !== 7'd0) begin tests_failed++; $display("FAIL reset_sl got %b exp 0", {sl_a12, sl_b12, sl_cin12}); end
      tests_run++; if (in_ready10 !== 1'b1 || out_valid10 !== 1'b0) begin tests_failed++; $display("FAIL reset_w10 got rdy=%b vld=%b exp 1/0", in_ready10, out_valid10); end
   endtask

   task automatic test_directed12();
      logic [11:0] s; logic co; int lat; logic [3:0] cins; logic ok;
      logic [12:0] exp_r;
      sel10 = 1'b0;
      run_op(12'hFFF, 12'h001, 1'b0, s, co, lat, cins, ok);
      tests_run++; if (!ok || lat != 4) begin tests_failed++; $display("FAIL fff_latency got %0d (valid=%b) exp 4", lat, ok); end
      tests_run++; if (s !== 12'h000 || co !== 1'b1) begin tests_failed++; $display("FAIL fff_sum got %h/%b exp 000/1", s, co); end
      retire();
      run_op(12'h5A5, 12'h35C, 1'b1, s, co, lat, cins, ok);
      exp_r = ref_add(12, 12'h5A5, 12'h35C, 1'b1);
      tests_run++; if (s !== 12'h902 || co !== 1'b0) begin tests_failed++; $display("FAIL 5a5_sum got %h/%b exp 902/0", s, co); end
      tests_run++; if ({co, s} !== exp_r) begin tests_failed++; $display("FAIL 5a5_model got %h exp %h", {co, s}, exp_r); end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (cins[k] !== ref_cin(12, 12'h5A5, 12'h35C, 1'b1, k)) begin
            tests_failed++;
            $display("FAIL 5a5_sl_cin slice %0d got %b exp %b", k, cins[k], ref_cin(12, 12'h5A5, 12'h35C, 1'b1, k));
         end
      end
      retire();
   endtask

   task automatic test_padded10();
      logic [11:0] s; logic co; int lat; logic [3:0] cins; logic ok;
      sel10 = 1'b1;
      run_op(12'h3FF, 12'h001, 1'b0, s, co, lat, cins, ok);
      tests_run++; if (!ok || s !== 12'h000 || co !== 1'b1) begin tests_failed++; $display("FAIL w10_3ff got %h/%b exp 000/1", s, co); end
      retire();
      run_op(12'h200, 12'h100, 1'b0, s, co, lat, cins, ok);
      tests_run++; if (!ok || s !== 12'h300 || co !== 1'b0) begin tests_failed++; $display("FAIL w10_200 got %h/%b exp 300/0", s, co); end
      retire();
      sel10 = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [11:0] s; logic co; int lat; logic [3:0] cins; logic ok;
      logic [12:0] exp_r;
      sel10 = 1'b0;
      exp_r = ref_add(12, 12'hABC, 12'h765, 1'b1);
      run_op(12'hABC, 12'h765, 1'b1, s, co, lat, cins, ok);
      tests_run++; if (!ok || {co, s} !== exp_r) begin tests_failed++; $display("FAIL bp_first got %h exp %h", {co, s}, exp_r); end
      in_valid = 1'b1; in_a = 12'h111; in_b = 12'h222; in_cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (out_valid12 !== 1'b1 || {out_cout12, out_sum12} !== exp_r || in_ready12 !== 1'b0 ||
             {sl_a12, sl_b12, sl_cin12} !== 7'd0) begin
            tests_failed++;
            $display("FAIL bp_hold cycle %0d got vld=%b res=%h rdy=%b exp 1/%h/0", i, out_valid12,
                     {out_cout12, out_sum12}, in_ready12, exp_r);
         end
      end
      retire();
      in_valid = 1'b0;
      tests_run++;
      if (in_ready12 !== 1'b1 || out_valid12 !== 1'b0 || out_sum12 !== 12'h000 || out_cout12 !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_retire got rdy=%b vld=%b sum=%h cout=%b exp 1/0/000/0", in_ready12, out_valid12, out_sum12, out_cout12);
      end
   endtask

   task automatic test_mid_reset();
      logic [11:0] s; logic co; int lat; logic [3:0] cins; logic ok;
      int seen;
      sel10 = 1'b0;
      in_a = 12'h7FF; in_b = 12'h7FF; in_cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (in_ready12 !== 1'b1 || out_valid12 !== 1'b0 || out_sum12 !== 12'h000 || sl_cin12 !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_state got rdy=%b vld=%b sum=%h slcin=%b exp 1/0/000/0", in_ready12, out_valid12, out_sum12, sl_cin12);
      end
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid12 === 1'b1) seen++;
      end
      tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL midrst_no_valid got %0d valid cycles exp 0", seen); end
      run_op(12'h001, 12'h001, 1'b0, s, co, lat, cins, ok);
      tests_run++; if (!ok || lat != 4 || s !== 12'h002 || co !== 1'b0) begin tests_failed++; $display("FAIL midrst_next got %h/%b lat %0d exp 002/0 lat 4", s, co, lat); end
      retire();
   endtask

   task automatic test_stub();
      logic [11:0] s; logic co; int lat; logic [3:0] cins; logic ok;
      sel10 = 1'b0;
      stub  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_op(12'($urandom), 12'($urandom), 1'($urandom), s, co, lat, cins, ok);
         tests_run++; if (!ok || s !== 12'h000 || co !== 1'b1) begin tests_failed++; $display("FAIL stub_%0d got %h/%b exp 000/1", i, s, co); end
         retire();
      end
      stub = 1'b0;
   endtask

   task automatic test_random();
      logic [11:0] s; logic co; int lat; logic [3:0] cins; logic ok;
      logic [11:0] a, b; logic c; logic [12:0] exp_r; logic [3:0] exp_c; int w;
      for (int pass = 0; pass < 2; pass++) begin
         w     = (pass == 0) ? 12 : 10;
         sel10 = (pass == 1);
         for (int i = 0; i < 25; i++) begin
            a = 12'($urandom) & 12'((1 << w) - 1);
            b = 12'($urandom) & 12'((1 << w) - 1);
            c = 1'($urandom);
            exp_r = ref_add(w, a, b, c);
            for (int k = 0; k < 4; k++) exp_c[k] = ref_cin(w, a, b, c, k);
            run_op(a, b, c, s, co, lat, cins, ok);
            tests_run++;
            if (!ok || lat != 4 || {co, s} !== exp_r || cins !== exp_c) begin
               tests_failed++;
               $display("FAIL rand_w%0d_%0d a=%h b=%h c=%b got %h lat %0d cin %b exp %h lat 4 cin %b",
                        w, i, a, b, c, {co, s}, lat, cins, exp_r, exp_c);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            retire();
         end
      end
      sel10 = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed12();
      test_padded10();
      test_backpressure();
      test_mid_reset();
      test_stub();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
